// File: rtl/period_meter.sv
// Measures the period and high time of a slow asynchronous signal in clk_in cycles.
// sig_in is synchronized, edge-detected, and timed by a single free-running count per period.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no reference rise yet (after reset or timeout); cnt held at 0
// MEASURE | counting clk_in cycles since the last synchronized rise
module period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 200000000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_lat;
    logic             rise;
    logic             fall;
    logic             at_limit;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign at_limit = (cnt == LIMIT);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            hi_lat       <= '0;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            s1           <= sig_in;
            s2           <= s1;
            s3           <= s2;
            period_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        cnt   <= ONE;
                        state <= MEASURE;
                    end else begin
                        cnt <= '0;
                    end
                end
                MEASURE: begin
                    // a rise on the limit cycle still completes the measurement
                    if (rise) begin
                        period       <= cnt;
                        high_time    <= hi_lat;
                        period_valid <= 1'b1;
                        locked       <= 1'b1;
                        timeout      <= 1'b0;
                        cnt          <= ONE;
                    end else if (at_limit) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        if (fall) begin
                            hi_lat <= cnt;
                        end
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus random waveforms,
// compared every cycle against a timestamp-based model of the measurement rules.
module tb_period_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic             clk_in;
    logic             rst;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             timeout;
    logic             locked;

    int checks = 0;
    int errors = 0;

    period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .sig_in       (sig_in),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .timeout      (timeout),
        .locked       (locked)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // model: sig_in as seen by the edge detector lags the input by two sampled cycles
    bit hist[$];
    int edge_n;
    bit armed;
    int last_rise;
    int hi_val;
    int exp_period;
    int exp_high;
    bit exp_valid;
    bit exp_timeout;
    bit exp_locked;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst_v, input bit sig_v);
        bit r;
        bit f;
        edge_n++;
        if (rst_v) begin
            hist        = {1'b0, 1'b0, 1'b0};
            armed       = 1'b0;
            last_rise   = 0;
            hi_val      = 0;
            exp_period  = 0;
            exp_high    = 0;
            exp_valid   = 1'b0;
            exp_timeout = 1'b0;
            exp_locked  = 1'b0;
            return;
        end
        r = hist[1] & ~hist[2];
        f = ~hist[1] & hist[2];
        hist.push_front(sig_v);
        void'(hist.pop_back());
        exp_valid = 1'b0;
        if (r) begin
            if (armed) begin
                exp_period  = edge_n - last_rise;
                exp_high    = hi_val;
                exp_valid   = 1'b1;
                exp_locked  = 1'b1;
                exp_timeout = 1'b0;
            end
            armed     = 1'b1;
            last_rise = edge_n;
        end else if (armed) begin
            if (edge_n - last_rise == TIMEOUT) begin
                exp_timeout = 1'b1;
                exp_locked  = 1'b0;
                armed       = 1'b0;
            end else if (f) begin
                hi_val = edge_n - last_rise;
            end
        end
    endtask

    task automatic cycle(input bit rst_v, input bit sig_v);
        @(negedge clk_in);
        rst    = rst_v;
        sig_in = sig_v;
        @(posedge clk_in);
        #1;
        model_step(rst_v, sig_v);
        check("period_valid", 32'(period_valid), 32'(exp_valid));
        check("timeout", 32'(timeout), 32'(exp_timeout));
        check("locked", 32'(locked), 32'(exp_locked));
        check("period", 32'(period), 32'(exp_period[CNT_W-1:0]));
        check("high_time", 32'(high_time), 32'(exp_high[CNT_W-1:0]));
    endtask

    task automatic square(input int per, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < per; i++)
                cycle(1'b0, i < hi);
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0);
    endtask

    initial begin
        int pulses;
        int rst_at;
        int per;
        int hi;
        rst    = 1'b1;
        sig_in = 1'b0;
        edge_n = 0;
        hist   = {1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0);
        check("reset_period", 32'(period), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);

        // divide-by-10: first pulse only at the second synchronized rise
        pulses = 0;
        for (int r = 0; r < 6; r++)
            for (int i = 0; i < 10; i++) begin
                cycle(1'b0, i < 5);
                if (period_valid) pulses++;
            end
        check("div10_period", 32'(period), 32'd10);
        check("div10_high", 32'(high_time), 32'd5);
        check("div10_locked", 32'(locked), 32'd1);
        check("div10_pulses", 32'(pulses), 32'd5);

        square(7, 2, 5);
        check("p7_period", 32'(period), 32'd7);
        check("p7_high", 32'(high_time), 32'd2);
        square(12, 9, 5);
        check("p12_period", 32'(period), 32'd12);
        check("p12_high", 32'(high_time), 32'd9);

        square(10, 5, 3);
        hold_low(30);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_locked", 32'(locked), 32'd0);
        check("to_period_hold", 32'(period), 32'd10);

        square(10, 5, 3);
        check("resume_timeout", 32'(timeout), 32'd0);
        check("resume_period", 32'(period), 32'd10);

        // rise lands exactly on the limit count: reported, no timeout
        square(TIMEOUT, 5, 4);
        check("limit_period", 32'(period), 32'(TIMEOUT));
        check("limit_timeout", 32'(timeout), 32'd0);
        square(TIMEOUT + 1, 5, 3);
        check("over_limit_timeout", 32'(timeout), 32'd1);

        square(10, 5, 4);
        rst_at = 3 + $urandom_range(0, 5);
        for (int i = 0; i < 10; i++)
            cycle(i == rst_at, i < 5);
        check("midrst_period", 32'(period), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        square(10, 5, 4);

        for (int k = 0; k < 40; k++) begin
            per = $urandom_range(2, TIMEOUT + 3);
            hi  = $urandom_range(1, per - 1);
            square(per, hi, $urandom_range(1, 3));
        end

        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0 ? ~sig_in : sig_in);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 32: width of the period and high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 200000000: number of clk_in cycles without a rising edge before the measurement is abandoned; legal range 2 to 2^CNT_W-2.
REQ-003 clk_in  input  1: single clock; all state is updated on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 sig_in  input  1: asynchronous slow periodic signal under measurement, e.g. a divided clock.
REQ-006 period  output  CNT_W: clk_in cycles between the last two detected rising edges of sig_in.
REQ-007 high_time  output  CNT_W: clk_in cycles sig_in was high within the last completed period.
REQ-008 period_valid  output  1: one-cycle pulse; period and high_time were updated this cycle.
REQ-009 timeout  output  1: level; no rising edge was seen for TIMEOUT cycles.
REQ-010 locked  output  1: level; at least one valid measurement since the last reset or timeout.

Function
REQ-011 sig_in SHALL pass through a two-flop synchronizer (s1, s2), followed by a third flop s3 used for edge detection.
REQ-012 Rise SHALL be s2 & ~s3 and fall SHALL be ~s2 & s3, both evaluated in the same cycle; at most one is true per cycle.
REQ-013 The FSM SHALL have two states: IDLE and MEASURE; the reset state is IDLE.
REQ-014 IDLE, rise: cnt <= 1; go to MEASURE; no period_valid pulse.
REQ-015 IDLE, no rise: cnt holds 0; fall edges are ignored.
REQ-016 MEASURE, no edge: cnt <= cnt + 1.
REQ-017 MEASURE, fall: hi_lat <= cnt (current value); cnt <= cnt + 1.
REQ-018 MEASURE, rise: period <= cnt; high_time <= hi_lat; period_valid <= 1; locked <= 1; timeout <= 0; cnt <= 1; stay in MEASURE.
REQ-019 Result: a sig_in period of N clk_in cycles yields period = N, and a high phase of H cycles yields high_time = H.
REQ-020 Latency: period_valid SHALL be high in the cycle after the third rising clk_in edge following the first sampling of sig_in high by s1.
REQ-021 Timeout: in MEASURE with cnt == TIMEOUT and no rise this cycle, the block SHALL set timeout <= 1, set locked <= 0, clear cnt to 0, and go to IDLE.
REQ-022 On timeout, period and high_time SHALL hold their last values.
REQ-023 Simultaneous rise and cnt == TIMEOUT: the rise wins; the measurement is reported and no timeout occurs.
REQ-024 Counter width: cnt never exceeds TIMEOUT, so no wrap-around SHALL occur.
REQ-025 All arithmetic SHALL be unsigned CNT_W bits.
REQ-026 period_valid SHALL be deasserted in every cycle not covered by REQ-018.
REQ-027 timeout SHALL stay high until the next period_valid pulse or reset.
REQ-028 If there is no fall within a period (constant-high glitch-free case impossible after a rise), hi_lat retains its previous value; no other special handling is required.

Reset
REQ-029 rst high at a clk_in edge SHALL clear the following: s1, s2, s3, cnt, hi_lat, period, high_time, period_valid, timeout and locked; the FSM goes to IDLE.
REQ-030 Reset SHALL take priority over every other event, including a rise in the same cycle.
REQ-031 After reset deasserts, the first rise SHALL only arm the measurement; the first period_valid SHALL occur at the second rise.
REQ-032 Reset mid-measurement SHALL discard any partial count; no period_valid pulse is produced for it.

Verification
REQ-033 Drive sig_in as a square wave with period 10 and high phase 5 (a divide-by-10 clock) -> period_valid pulses every 10 cycles, first pulse at the second rise; period = 10, high_time = 5, locked = 1.
REQ-034 Drive sig_in with period 7, high 2, then switch to period 12, high 9 -> reports 7/2, then exactly one transitional report, then 12/9 thereafter.
REQ-035 With TIMEOUT = 20, let sig_in lock at period 10, then hold it low -> timeout = 1 and locked = 0 twenty cycles after the last rise detection; period holds 10.
REQ-036 Resume sig_in with period 10 after the timeout -> first rise produces no pulse; second rise gives period_valid, period = 10, and timeout returns to 0.
REQ-037 Assert rst for 1 cycle midway through a locked period-10 stream -> all outputs are 0 the next cycle; the next valid report comes at the second rise after reset.
REQ-038 With TIMEOUT = 10, drive period 10 -> the rise coincides with cnt == 10; period = 10 is reported and timeout stays 0.
